// File: rtl/poly_scalar_modmul.sv
// Bit-serial streaming scaler: out_coef = (in_coef * scalar) mod q, one coefficient at a time.
// Define POLY_SCALE_SIGNED_EN to treat in_coef as two's-complement (one extra negate cycle).
module poly_scalar_modmul #(
  parameter int N    = 1024,
  parameter int W    = 30,
  parameter int PT_W = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    scalar,
  input  logic [W-1:0]    modulus,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PT_W-1:0] in_coef,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_coef,
  output logic            out_last,
  output logic            done
);
  localparam int IW = $clog2(N);
`ifdef POLY_SCALE_SIGNED_EN
  localparam int STEPS = PT_W + 1;
`else
  localparam int STEPS = PT_W;
`endif
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, COMPUTE, HOLD, FINISH} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   index_reg;
  logic [CW-1:0]   step_reg;
  logic [W-1:0]    acc_reg;
  logic [W-1:0]    scalar_reg;
  logic [W-1:0]    modulus_reg;
  logic [PT_W-1:0] coef_reg;
`ifdef POLY_SCALE_SIGNED_EN
  logic            neg_reg;
`endif

  logic          last_step, at_last;
  logic [W:0]    dbl, dbl_red, sum;
  logic [W-1:0]  sum_red, step_val;

  assign last_step = (step_reg == CW'(STEPS - 1));
  assign at_last   = (index_reg == IW'(N - 1));

  // One shift-and-add step: both reductions are a single conditional subtract since inputs are < q.
  assign dbl      = {acc_reg, 1'b0};
  assign dbl_red  = (dbl >= {1'b0, modulus_reg}) ? dbl - {1'b0, modulus_reg} : dbl;
  assign sum      = dbl_red + {1'b0, scalar_reg};
  assign sum_red  = W'((sum >= {1'b0, modulus_reg}) ? sum - {1'b0, modulus_reg} : sum);
  assign step_val = coef_reg[PT_W-1] ? sum_red : dbl_red[W-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = ACCEPT;
      ACCEPT:  if (in_valid)  state_next = COMPUTE;
      COMPUTE: if (last_step) state_next = HOLD;
      HOLD:    if (out_ready) state_next = at_last ? FINISH : ACCEPT;
      FINISH:                 state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_reg   <= '0;
      step_reg    <= '0;
      acc_reg     <= '0;
      scalar_reg  <= '0;
      modulus_reg <= '0;
      coef_reg    <= '0;
`ifdef POLY_SCALE_SIGNED_EN
      neg_reg     <= 1'b0;
`endif
    end else begin
      if (state_reg == IDLE && start) begin
        scalar_reg  <= scalar;
        modulus_reg <= modulus;
        index_reg   <= '0;
      end
      if (state_reg == ACCEPT && in_valid) begin
        acc_reg  <= '0;
        step_reg <= '0;
`ifdef POLY_SCALE_SIGNED_EN
        // Most negative value wraps to itself, which reads back as the right unsigned magnitude.
        coef_reg <= in_coef[PT_W-1] ? (~in_coef) + PT_W'(1) : in_coef;
        neg_reg  <= in_coef[PT_W-1];
`else
        coef_reg <= in_coef;
`endif
      end
      if (state_reg == COMPUTE) begin
        step_reg <= step_reg + CW'(1);
`ifdef POLY_SCALE_SIGNED_EN
        if (last_step) begin
          if (neg_reg && acc_reg != '0) acc_reg <= modulus_reg - acc_reg;
        end else begin
          acc_reg  <= step_val;
          coef_reg <= coef_reg << 1;
        end
`else
        acc_reg  <= step_val;
        coef_reg <= coef_reg << 1;
`endif
      end
      if (state_reg == HOLD && out_ready) index_reg <= index_reg + IW'(1);
    end
  end

  assign busy      = (state_reg != IDLE);
  assign in_ready  = (state_reg == ACCEPT);
  assign out_valid = (state_reg == HOLD);
  assign out_coef  = acc_reg;
  assign out_last  = (state_reg == HOLD) && at_last;
  assign done      = (state_reg == FINISH);
endmodule

// File: tb/tb_poly_scalar_modmul.sv
// Directed bench for poly_scalar_modmul: one PT_W=1/N=4 instance and one PT_W=2/N=2 instance.
module tb_poly_scalar_modmul;
  localparam int A_PT = 1;
  localparam int B_PT = 2;
`ifdef POLY_SCALE_SIGNED_EN
  localparam int EXTRA = 1;
  localparam logic [29:0] A1 = 30'd999998;
  localparam logic [29:0] B3 = 30'd37;
  localparam logic [29:0] B2 = 30'd74;
`else
  localparam int EXTRA = 0;
  localparam logic [29:0] A1 = 30'd5;
  localparam logic [29:0] B3 = 30'd83;
  localparam logic [29:0] B2 = 30'd23;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel, start, in_valid, out_ready;
  logic [29:0] scalar, modulus;
  logic [1:0]  in_coef;

  logic        a_start, a_in_valid, a_out_ready, a_busy, a_in_ready, a_out_valid, a_out_last, a_done;
  logic [29:0] a_out_coef;
  logic        b_start, b_in_valid, b_out_ready, b_busy, b_in_ready, b_out_valid, b_out_last, b_done;
  logic [7:0]  b_out_coef;
  logic        busy, in_ready, out_valid, out_last, done;
  logic [29:0] out_coef;

  assign a_start     = start & ~sel;
  assign a_in_valid  = in_valid & ~sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_start     = start & sel;
  assign b_in_valid  = in_valid & sel;
  assign b_out_ready = out_ready & sel;
  assign busy      = sel ? b_busy : a_busy;
  assign in_ready  = sel ? b_in_ready : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign out_last  = sel ? b_out_last : a_out_last;
  assign done      = sel ? b_done : a_done;
  assign out_coef  = sel ? {22'd0, b_out_coef} : a_out_coef;

  poly_scalar_modmul #(.N(4), .W(30), .PT_W(A_PT)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .scalar(scalar), .modulus(modulus),
    .busy(a_busy), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_coef(in_coef[0:0]),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_coef(a_out_coef),
    .out_last(a_out_last), .done(a_done)
  );

  poly_scalar_modmul #(.N(2), .W(8), .PT_W(B_PT)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .scalar(scalar[7:0]), .modulus(modulus[7:0]),
    .busy(b_busy), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_coef(in_coef),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_coef(b_out_coef),
    .out_last(b_out_last), .done(b_done)
  );

  int  pass_cnt = 0;
  int  total_cnt = 0;
  time prev_hs = 0;

  task automatic do_start(input logic [29:0] sc, input logic [29:0] q);
    start = 1'b1; scalar = sc; modulus = q;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL start_ack: busy=%b in_ready=%b required 1 1", busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic xfer(input logic [1:0] coef, input logic [29:0] exp, input logic last,
                      input int stall, input bit gap_chk);
    int t;
    int lat_exp;
    lat_exp = (sel ? B_PT : A_PT) + 1 + EXTRA;
    in_coef = coef; in_valid = 1'b1; t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL in_handshake: in_ready=%b required 1", in_ready);
    else pass_cnt++;
    if (gap_chk) begin
      total_cnt++;
      if (($time - prev_hs) != time'((lat_exp + 1) * 10))
        $display("FAIL throughput: gap=%0t required %0d", $time - prev_hs, (lat_exp + 1) * 10);
      else pass_cnt++;
    end
    prev_hs = $time;
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL in_ready_compute: got %b required 0", in_ready);
    else pass_cnt++;
    t = 1;
    while (out_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    total_cnt++;
    if (t != lat_exp) $display("FAIL latency: got %0d required %0d", t, lat_exp);
    else pass_cnt++;
    total_cnt++;
    if (out_coef !== exp) $display("FAIL out_coef(in=%0d): got %0d required %0d", coef, out_coef, exp);
    else pass_cnt++;
    total_cnt++;
    if (out_last !== last) $display("FAIL out_last: got %b required %b", out_last, last);
    else pass_cnt++;
    repeat (stall) begin
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || out_coef !== exp || in_ready !== 1'b0)
        $display("FAIL hold: valid=%b coef=%0d in_ready=%b required 1 %0d 0",
                 out_valid, out_coef, in_ready, exp);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (done !== last || busy !== 1'b1)
      $display("FAIL post_xfer: done=%b busy=%b required %b 1", done, busy, last);
    else pass_cnt++;
    if (last) begin
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL finish: done=%b busy=%b required 0 0", done, busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({a_busy, a_in_ready, a_out_valid, a_out_last, a_done} !== 5'b0)
      $display("FAIL reset_a_flags: got %b required 00000",
               {a_busy, a_in_ready, a_out_valid, a_out_last, a_done});
    else pass_cnt++;
    total_cnt++;
    if (a_out_coef !== 30'd0) $display("FAIL reset_a_coef: got %0d required 0", a_out_coef);
    else pass_cnt++;
    total_cnt++;
    if ({b_busy, b_in_ready, b_out_valid, b_out_last, b_done} !== 5'b0 || b_out_coef !== 8'd0)
      $display("FAIL reset_b: flags=%b coef=%0d required 00000 0",
               {b_busy, b_in_ready, b_out_valid, b_out_last, b_done}, b_out_coef);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_pt1_run();
    sel = 1'b0;
    do_start(30'd5, 30'd1000003);
    xfer(2'd1, A1, 1'b0, 0, 1'b0);
    xfer(2'd0, 30'd0, 1'b0, 0, 1'b1);
    xfer(2'd1, A1, 1'b0, 0, 1'b1);
    xfer(2'd1, A1, 1'b1, 0, 1'b1);
  endtask

  task automatic test_pt2_run();
    sel = 1'b1;
    do_start(30'd60, 30'd97);
    xfer(2'd3, B3, 1'b0, 0, 1'b0);
    xfer(2'd2, B2, 1'b1, 0, 1'b1);
    do_start(30'd60, 30'd97);
    xfer(2'd1, 30'd60, 1'b0, 0, 1'b0);
    xfer(2'd0, 30'd0, 1'b1, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    do_start(30'd60, 30'd97);
    xfer(2'd1, 30'd60, 1'b0, 5, 1'b0);
    xfer(2'd3, B3, 1'b1, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    int done_seen;
    sel = 1'b1;
    do_start(30'd60, 30'd97);
    in_coef = 2'd3; in_valid = 1'b1; t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b required 0 0 0",
               busy, in_ready, out_valid);
    else pass_cnt++;
    done_seen = 0;
    repeat (6) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (done_seen != 0) $display("FAIL reset_mid_done: pulses=%0d required 0", done_seen);
    else pass_cnt++;
    do_start(30'd60, 30'd97);
    xfer(2'd2, B2, 1'b0, 0, 1'b0);
    xfer(2'd3, B3, 1'b1, 0, 1'b1);
  endtask

  task automatic test_ignore_start();
    sel = 1'b0;
    do_start(30'd5, 30'd1000003);
    xfer(2'd1, A1, 1'b0, 0, 1'b0);
    start = 1'b1; scalar = 30'd7; modulus = 30'd11;
    @(negedge clk);
    start = 1'b0;
    xfer(2'd1, A1, 1'b0, 0, 1'b0);
    xfer(2'd0, 30'd0, 1'b0, 0, 1'b0);
    xfer(2'd1, A1, 1'b1, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    scalar = '0; modulus = '0; in_coef = '0;
    test_reset();
    test_pt1_run();
    test_pt2_run();
    test_backpressure();
    test_reset_mid();
    test_ignore_start();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
